// File: rtl/adder_pkg.sv
// Shared constants and parameter helpers for the pipelined adder family.
package adder_pkg;

    localparam int unsigned ADDER_DEF_WIDTH  = 16;
    localparam int unsigned ADDER_DEF_STAGES = 4;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit stages_ok(input int unsigned width,
                                     input int unsigned stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder; one instance per pipeline slice.
module adder_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);

    always_comb begin
        {co, s} = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with valid/ready handshakes, STAGES carry slices.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADDER_DEF_WIDTH,
    parameter int unsigned STAGES = ADDER_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [SW-1:0]     sum_al [STAGES];

    assign out_valid = vld_q[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned K      = k;
        // Rank register plus the deskew delays that line this slice up with the last one.
        localparam int unsigned DESKEW = STAGES - k;

        logic [SW-1:0] xk, yk, sk;
        logic          ck, cok, cq;
        logic [SW-1:0] sd [DESKEW];

        if (k == 0) begin : g_head
            assign xk = a[SW-1:0];
            assign yk = b[SW-1:0];
            assign ck = cin;
        end else begin : g_skew
            logic [SW-1:0] xd [K];
            logic [SW-1:0] yd [K];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < K; i++) begin
                        xd[i] <= '0;
                        yd[i] <= '0;
                    end
                end else if (adv) begin
                    xd[0] <= a[K*SW +: SW];
                    yd[0] <= b[K*SW +: SW];
                    for (int unsigned i = 1; i < K; i++) begin
                        xd[i] <= xd[i-1];
                        yd[i] <= yd[i-1];
                    end
                end
            end

            assign xk = xd[K-1];
            assign yk = yd[K-1];
            assign ck = g_slice[k-1].cq;
        end

        adder_slice #(.SW(SW)) u_slice (
            .x  (xk),
            .y  (yk),
            .ci (ck),
            .s  (sk),
            .co (cok)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cq <= 1'b0;
                for (int unsigned i = 0; i < DESKEW; i++) begin
                    sd[i] <= '0;
                end
            end else if (adv) begin
                cq    <= cok;
                sd[0] <= sk;
                for (int unsigned i = 1; i < DESKEW; i++) begin
                    sd[i] <= sd[i-1];
                end
            end
        end

        assign sum_al[k] = sd[DESKEW-1];
    end

    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum[k*SW +: SW] = sum_al[k];
        end
    end

    assign cout = g_slice[STAGES-1].cq;

`ifdef PIPELINED_ADDER_OVF_EN
    // MSB operands arrive already skewed at the last slice, so ovf shares its rank register.
    logic ovf_d;

    always_comb begin
        ovf_d = (g_slice[STAGES-1].xk[SW-1] == g_slice[STAGES-1].yk[SW-1]) &&
                (g_slice[STAGES-1].sk[SW-1] != g_slice[STAGES-1].xk[SW-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule
